// File: rtl/sdpram_fifo_ctrl.sv
// FIFO controller around an external simple-dual-port RAM (1-cycle read latency),
// with a 2-entry output buffer so the downstream side can stall without losing reads.
module sdpram_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH),
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  empty,
    output logic [STRB_WIDTH-1:0] ram_wena,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_renb,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_doutb
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(MEM_DEPTH);

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH+1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic                  inflight_q, inflight_d;

    logic [ADDR_WIDTH:0]   ram_level;
    logic [1:0]            occ_after_pop;
    logic                  push, pop, rd_en;

    always_comb begin
        ram_level = wr_ptr_q - rd_ptr_q;
        s_ready   = (ram_level < DEPTH_L);
        // Writes are blocked while rst is high even though s_ready reads 1 then.
        push      = s_valid && s_ready && !rst;
        m_valid   = (buf_cnt_q != 2'd0);
        pop       = m_valid && m_ready;
        // Counting the slot freed by this cycle's pop keeps the read pipe full at one word per cycle.
        occ_after_pop = buf_cnt_q - {1'b0, pop};
        rd_en     = (ram_level != '0) && ((occ_after_pop + {1'b0, inflight_q}) < 2'd2);

        m_data    = buf_q[0];
        count     = count_q;
        empty     = (count_q == '0);
        ram_wena  = push ? {STRB_WIDTH{1'b1}} : {STRB_WIDTH{1'b0}};
        ram_addra = wr_ptr_q[ADDR_WIDTH-1:0];
        ram_dina  = s_data;
        ram_renb  = rd_en;
        ram_addrb = rd_ptr_q[ADDR_WIDTH-1:0];

        wr_ptr_d   = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_en};
        inflight_d = rd_en;

        buf_d[0] = buf_q[0];
        buf_d[1] = buf_q[1];
        if (pop) begin
            buf_d[0] = buf_q[1];
        end
        if (inflight_q) begin
            buf_d[occ_after_pop[0]] = ram_doutb;
        end
        buf_cnt_d = occ_after_pop + {1'b0, inflight_q};

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            buf_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            buf_q[0]   <= buf_d[0];
            buf_q[1]   <= buf_d[1];
            buf_cnt_q  <= buf_cnt_d;
            inflight_q <= inflight_d;
        end
    end

endmodule
